// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives the ROM address and hides the ROM's one-cycle
// read latency behind a valid/ready handshake with a one-entry skid buffer.
`ifndef ROM_ADDRESS_BITWIDTH
`define ROM_ADDRESS_BITWIDTH 16
`endif

module fetch_unit #(
   parameter int unsigned       ADDR_W   = `ROM_ADDRESS_BITWIDTH,
   parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_enable,
   output logic [ADDR_W-1:0] rom_address,
   input  logic [31:0]       rom_data,
   input  logic              redirect_valid,
   input  logic [ADDR_W-1:0] redirect_pc,
   output logic              inst_valid,
   input  logic              inst_ready,
   output logic [31:0]       inst_data,
   output logic [ADDR_W-1:0] inst_pc
);

   logic [ADDR_W-1:0] r_pc;
   logic              r_req_valid;
   logic [ADDR_W-1:0] r_req_pc;
   logic              r_buf_valid;
   logic [31:0]       r_buf_data;
   logic [ADDR_W-1:0] r_buf_pc;

   logic [ADDR_W-1:0] w_target;
   logic              w_issue;
   logic              w_capture;

   assign w_target  = redirect_pc & ~ADDR_W'(3);
   assign w_issue   = fetch_enable
                    & !(r_buf_valid & !inst_ready)
                    & !(r_req_valid & !inst_ready & !r_buf_valid);
   // The ROM word is only on rom_data for one cycle; park it if decode is not taking it.
   assign w_capture = r_req_valid & !r_buf_valid & !inst_ready;

   always_comb begin
      rom_address = redirect_valid ? w_target : r_pc;
      inst_valid  = (r_buf_valid | r_req_valid) & !redirect_valid;
      inst_data   = '0;
      inst_pc     = r_pc;
      if (r_buf_valid) begin
         inst_data = r_buf_data;
         inst_pc   = r_buf_pc;
      end else if (r_req_valid) begin
         inst_data = rom_data;
         inst_pc   = r_req_pc;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_pc        <= RESET_PC;
         r_req_valid <= 1'b0;
         r_req_pc    <= RESET_PC;
         r_buf_valid <= 1'b0;
         r_buf_data  <= '0;
         r_buf_pc    <= RESET_PC;
      end else if (redirect_valid) begin
         r_buf_valid <= 1'b0;
         r_req_valid <= fetch_enable;
         r_req_pc    <= w_target;
         r_pc        <= fetch_enable ? w_target + ADDR_W'(4) : w_target;
      end else begin
         if (w_issue) begin
            r_pc        <= r_pc + ADDR_W'(4);
            r_req_valid <= 1'b1;
            r_req_pc    <= r_pc;
         end else begin
            r_req_valid <= 1'b0;
         end
         if (r_buf_valid && inst_ready) begin
            r_buf_valid <= 1'b0;
         end else if (w_capture) begin
            r_buf_valid <= 1'b1;
            r_buf_data  <= rom_data;
            r_buf_pc    <= r_req_pc;
         end
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit with an 8-bit address space and a
// one-cycle registered ROM whose word k holds 0x1000_0000 + k.
module tb_fetch_unit;

   localparam int unsigned AW = 8;

   logic          clk = 1'b0;
   logic          reset;
   logic          fetch_enable;
   logic [AW-1:0] rom_address;
   logic [31:0]   rom_data;
   logic          redirect_valid;
   logic [AW-1:0] redirect_pc;
   logic          inst_valid;
   logic          inst_ready;
   logic [31:0]   inst_data;
   logic [AW-1:0] inst_pc;

   int n_tests = 0;
   int n_fail  = 0;

   typedef struct {
      logic          rv;
      logic [AW-1:0] rpc;
      logic          en;
      logic          rdy;
      logic          ev;
      logic [AW-1:0] epc;
      logic [31:0]   edata;
      logic [AW-1:0] eaddr;
   } vec_t;

   vec_t vecs[$];

   fetch_unit #(
      .ADDR_W   (AW),
      .RESET_PC (8'h00)
   ) dut (
      .clk            (clk),
      .reset          (reset),
      .fetch_enable   (fetch_enable),
      .rom_address    (rom_address),
      .rom_data       (rom_data),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .inst_valid     (inst_valid),
      .inst_ready     (inst_ready),
      .inst_data      (inst_data),
      .inst_pc        (inst_pc)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) rom_data <= 32'h1000_0000 + 32'(rom_address[AW-1:2]);

   function automatic void add(input logic rv, input logic [AW-1:0] rpc, input logic en,
                               input logic rdy, input logic ev, input logic [AW-1:0] epc,
                               input logic [31:0] edata, input logic [AW-1:0] eaddr);
      vec_t v;
      v.rv = rv; v.rpc = rpc; v.en = en; v.rdy = rdy;
      v.ev = ev; v.epc = epc; v.edata = edata; v.eaddr = eaddr;
      vecs.push_back(v);
   endfunction

   task automatic check(input string name, input logic ev, input logic [AW-1:0] epc,
                        input logic [31:0] edata, input logic [AW-1:0] eaddr);
      n_tests++;
      if (inst_valid !== ev || inst_pc !== epc || inst_data !== edata || rom_address !== eaddr)
      begin
         n_fail++;
         $display("FAIL %s: got valid=%b pc=%h data=%h addr=%h, expected valid=%b pc=%h data=%h addr=%h",
                  name, inst_valid, inst_pc, inst_data, rom_address, ev, epc, edata, eaddr);
      end
   endtask

   initial begin
      //   rv rpc    en rdy  ev  pc     data          rom_addr
      // streaming from reset
      add(0, 8'h00, 1, 1,  0, 8'h00, 32'h0,         8'h00);
      add(0, 8'h00, 1, 1,  1, 8'h00, 32'h1000_0000, 8'h04);
      add(0, 8'h00, 1, 1,  1, 8'h04, 32'h1000_0001, 8'h08);
      // three cycles without ready while 0x8 is offered
      add(0, 8'h00, 1, 0,  1, 8'h08, 32'h1000_0002, 8'h0C);
      add(0, 8'h00, 1, 0,  1, 8'h08, 32'h1000_0002, 8'h0C);
      add(0, 8'h00, 1, 0,  1, 8'h08, 32'h1000_0002, 8'h0C);
      add(0, 8'h00, 1, 1,  1, 8'h08, 32'h1000_0002, 8'h0C);
      add(0, 8'h00, 1, 1,  1, 8'h0C, 32'h1000_0003, 8'h10);
      add(0, 8'h00, 1, 1,  1, 8'h10, 32'h1000_0004, 8'h14);
      // stall into buffer, then redirect to 0x43 flushes it
      add(0, 8'h00, 1, 0,  1, 8'h14, 32'h1000_0005, 8'h18);
      add(1, 8'h43, 1, 0,  0, 8'h14, 32'h1000_0005, 8'h40);
      add(0, 8'h00, 1, 1,  1, 8'h40, 32'h1000_0010, 8'h44);
      add(0, 8'h00, 1, 1,  1, 8'h44, 32'h1000_0011, 8'h48);
      // redirect to top of address space (low bits ignored), wrap to 0
      add(1, 8'hFE, 1, 1,  0, 8'h48, 32'h1000_0012, 8'hFC);
      add(0, 8'h00, 1, 1,  1, 8'hFC, 32'h1000_003F, 8'h00);
      add(0, 8'h00, 1, 1,  1, 8'h00, 32'h1000_0000, 8'h04);
      // disable with a word in flight and no ready: word is kept then delivered
      add(0, 8'h00, 0, 0,  1, 8'h04, 32'h1000_0001, 8'h08);
      add(0, 8'h00, 0, 0,  1, 8'h04, 32'h1000_0001, 8'h08);
      add(0, 8'h00, 0, 1,  1, 8'h04, 32'h1000_0001, 8'h08);
      add(0, 8'h00, 0, 1,  0, 8'h08, 32'h0,         8'h08);
      add(0, 8'h00, 0, 1,  0, 8'h08, 32'h0,         8'h08);
      // redirect while disabled only moves the PC
      add(1, 8'h20, 0, 1,  0, 8'h08, 32'h0,         8'h20);
      add(0, 8'h00, 0, 1,  0, 8'h20, 32'h0,         8'h20);
      add(0, 8'h00, 1, 1,  0, 8'h20, 32'h0,         8'h20);
      add(0, 8'h00, 1, 1,  1, 8'h20, 32'h1000_0008, 8'h24);
      // leave a word in the buffer for the reset sequence
      add(0, 8'h00, 1, 0,  1, 8'h24, 32'h1000_0009, 8'h28);

      reset          = 1'b1;
      fetch_enable   = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      repeat (2) @(posedge clk);
      #1 reset = 1'b0;

      for (int i = 0; i < vecs.size(); i++) begin
         redirect_valid = vecs[i].rv;
         redirect_pc    = vecs[i].rpc;
         fetch_enable   = vecs[i].en;
         inst_ready     = vecs[i].rdy;
         @(negedge clk);
         check($sformatf("vec%0d", i), vecs[i].ev, vecs[i].epc, vecs[i].edata, vecs[i].eaddr);
         @(posedge clk);
         #1;
      end

      // asynchronous reset with the buffer occupied
      fetch_enable   = 1'b1;
      inst_ready     = 1'b1;
      redirect_valid = 1'b0;
      reset          = 1'b1;
      #1;
      check("reset_async", 1'b0, 8'h00, 32'h0, 8'h00);
      @(posedge clk);
      #1 reset = 1'b0;
      @(negedge clk);
      check("reset_release", 1'b0, 8'h00, 32'h0, 8'h00);
      @(posedge clk);
      @(negedge clk);
      check("restart_0", 1'b1, 8'h00, 32'h1000_0000, 8'h04);
      @(posedge clk);
      @(negedge clk);
      check("restart_4", 1'b1, 8'h04, 32'h1000_0001, 8'h08);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
